// File: rtl/adder4_pkg.sv
// Shared constants and types for the registered 4-bit add/subtract unit.
package adder4_pkg;

  localparam int WIDTH = 4;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             cout;
    logic             ovf;
  } sum_t;

endpackage

// File: rtl/adder4_fa.sv
// One-bit full adder cell used to build the ripple carry chain.
// Latency: combinational. Backpressure: none.
module adder4_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/adder4.sv
// Registered add/subtract with carry, overflow, zero and sign flags.
// Latency: 1 cycle from in_valid to out_valid. Backpressure: none, one result per cycle.
module adder4
  import adder4_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zf,
  output logic         sf,
  output logic         out_valid
);

  logic [W-1:0] bx;
  logic [W:0]   c;
  logic [W-1:0] sum;

  // Subtraction is a + ~b + 1, so cin becomes a borrow by flipping it.
  assign bx   = (sub == OP_SUB) ? ~b : b;
  assign c[0] = cin ^ (sub == OP_SUB);

  for (genvar i = 0; i < W; i++) begin : g_fa
    adder4_fa u_fa (
      .a  (a[i]),
      .b  (bx[i]),
      .ci (c[i]),
      .s  (sum[i]),
      .co (c[i+1])
    );
  end

  logic [W-1:0] s_d, s_q;
  logic         cout_d, cout_q;
  logic         ovf_d, ovf_q;
  logic         zf_d, zf_q;
  logic         out_valid_d, out_valid_q;

  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    ovf_d       = ovf_q;
    zf_d        = zf_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = sum;
      cout_d = c[W];
      ovf_d  = c[W-1] ^ c[W];
      zf_d   = (sum == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      zf_q        <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      ovf_q       <= ovf_d;
      zf_q        <= zf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zf        = zf_q;
  assign sf        = s_q[W-1];
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder4.sv
// Scoreboard bench for adder4: directed vectors, hold, reset and exhaustive sweep.
module tb_adder4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] a, b;
  logic       cin, sub;
  logic [3:0] s;
  logic       cout, ovf, zf, sf, out_valid;

  adder4 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf),
    .zf        (zf),
    .sf        (sf),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] s;
    logic       cout;
    logic       ovf;
    logic       zf;
    logic       sf;
  } exp_t;

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       sub;
    exp_t       e;
  } vec_t;

  exp_t q[$];
  exp_t last_exp;
  int   n_cmp = 0;
  int   n_err = 0;
  vec_t vecs[13];

  function automatic exp_t ref_model(logic [3:0] xa, logic [3:0] xb, logic xc, logic xs);
    exp_t r;
    int   ru, rs, sa, sb;
    sa = int'($signed(xa));
    sb = int'($signed(xb));
    if (!xs) begin
      ru     = int'(xa) + int'(xb) + int'(xc);
      rs     = sa + sb + int'(xc);
      r.cout = (ru > 15);
    end else begin
      ru     = int'(xa) - int'(xb) - int'(xc);
      rs     = sa - sb - int'(xc);
      r.cout = (ru >= 0);
    end
    r.s   = 4'(ru);
    r.ovf = (rs > 7) || (rs < -8);
    r.zf  = (r.s == 4'd0);
    r.sf  = r.s[3];
    return r;
  endfunction

  function automatic exp_t outs();
    exp_t o;
    o.s = s; o.cout = cout; o.ovf = ovf; o.zf = zf; o.sf = sf;
    return o;
  endfunction

  task automatic check(string name, exp_t got, exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got s=%0d cout=%b ovf=%b zf=%b sf=%b, want s=%0d cout=%b ovf=%b zf=%b sf=%b",
               name, got.s, got.cout, got.ovf, got.zf, got.sf,
               want.s, want.cout, want.ovf, want.zf, want.sf);
    end
  endtask

  task automatic check_bit(string name, logic got, logic want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", name, got, want);
    end
  endtask

  // Monitor: every presented result must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_out_valid: got out_valid=1 with s=%0d, want no result", s);
      end else begin
        check("result", outs(), q.pop_front());
      end
    end
  end

  task automatic drive(logic [3:0] xa, logic [3:0] xb, logic xc, logic xs, exp_t e);
    @(posedge clk);
    #1;
    in_valid = 1'b1; a = xa; b = xb; cin = xc; sub = xs;
    q.push_back(e);
    last_exp = e;
  endtask

  task automatic idle_hold(int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (i > 0) begin
        check("hold_outputs", outs(), last_exp);
        check_bit("hold_out_valid", out_valid, 1'b0);
      end
      in_valid = 1'b0;
      a = 4'(i * 5 + 3); b = 4'(~i); cin = i[0]; sub = ~i[0];
    end
  endtask

  exp_t rst_exp;

  initial begin
    rst_exp = '{s: 4'd0, cout: 1'b0, ovf: 1'b0, zf: 1'b1, sf: 1'b0};

    // a, b, cin, sub, {s, cout, ovf, zf, sf}
    vecs[0]  = '{4'd0,  4'd0,  1'b0, 1'b0, '{4'd0,  1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[1]  = '{4'd1,  4'd0,  1'b0, 1'b0, '{4'd1,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[2]  = '{4'd2,  4'd0,  1'b0, 1'b0, '{4'd2,  1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[3]  = '{4'd2,  4'd7,  1'b0, 1'b0, '{4'd9,  1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[4]  = '{4'd13, 4'd7,  1'b0, 1'b0, '{4'd4,  1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[5]  = '{4'd11, 4'd7,  1'b0, 1'b0, '{4'd2,  1'b1, 1'b0, 1'b0, 1'b0}};
    vecs[6]  = '{4'd11, 4'd9,  1'b0, 1'b0, '{4'd4,  1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[7]  = '{4'd11, 4'd14, 1'b0, 1'b0, '{4'd9,  1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[8]  = '{4'd2,  4'd7,  1'b0, 1'b1, '{4'd11, 1'b0, 1'b0, 1'b0, 1'b1}};
    vecs[9]  = '{4'd7,  4'd7,  1'b0, 1'b1, '{4'd0,  1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[10] = '{4'd15, 4'd0,  1'b1, 1'b0, '{4'd0,  1'b1, 1'b0, 1'b1, 1'b0}};
    vecs[11] = '{4'd7,  4'd0,  1'b1, 1'b0, '{4'd8,  1'b0, 1'b1, 1'b0, 1'b1}};
    vecs[12] = '{4'd5,  4'd9,  1'b1, 1'b1, '{4'd11, 1'b0, 1'b1, 1'b0, 1'b1}};

    rst_n = 1'b0; in_valid = 1'b0; a = 4'd0; b = 4'd0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset_values", outs(), rst_exp);
    check_bit("reset_out_valid", out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].e);
    idle_hold(4);
    for (int i = 8; i < 13; i++) drive(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].e);
    idle_hold(3);

    // Mid-operation reset: the result already in the output register is dropped.
    @(posedge clk);
    #1;
    in_valid = 1'b1; a = 4'd9; b = 4'd3; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_values", outs(), rst_exp);
    check_bit("async_reset_out_valid", out_valid, 1'b0);
    in_valid = 1'b1; a = 4'd3; b = 4'd4; cin = 1'b0; sub = 1'b0;
    @(posedge clk);
    #1;
    check("reset_held_values", outs(), rst_exp);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back(ref_model(4'd3, 4'd4, 1'b0, 1'b0));
    last_exp = ref_model(4'd3, 4'd4, 1'b0, 1'b0);
    idle_hold(3);

    for (int i = 0; i < 4096; i++) begin
      logic [11:0] k;
      k = 12'(i);
      drive(k[3:0], k[7:4], k[8], k[9], ref_model(k[3:0], k[7:4], k[8], k[9]));
    end
    idle_hold(3);

    repeat (3) @(posedge clk);
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d results outstanding, want 0", q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got simulation still running, want completion");
    $fatal(1, "timeout");
  end

endmodule
